// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state enum, fixed widths and the byte-lane merge function.
package dmem_pkg;

    localparam int DATA_W = 64;
    localparam int MASK_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Replace only the byte lanes whose mask bit is set.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [MASK_W-1:0] mask
    );
        logic [DATA_W-1:0] r;
        r = old_word;
        for (int i = 0; i < MASK_W; i++) begin
            if (mask[i]) begin
                r[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64-bit storage with one lane-masked write port and one read port.
// Ports: clk, wen, idx (word index), wmask, wdata, rdata (word at idx). No reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic              clk,
    input  logic              wen,
    input  logic [IDX_W-1:0]  idx,
    input  logic [MASK_W-1:0] wmask,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[idx] <= merge_bytes(mem[idx], wdata, wmask);
        end
    end

    // Read is sampled by the top only on its commit edge.
    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: one outstanding word request, programmable latency.
// Ports: clk, rst_n, req_* (valid/ready request), resp_* (valid/ready response).
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int              XLEN    = 64,
    parameter int              DEPTH   = 256,
    parameter logic [XLEN-1:0] BASE    = 'h8000_0000,
    parameter int              LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_wen;
    logic [XLEN-1:0]   lat_addr;
    logic [XLEN-1:0]   lat_wdata;
    logic [MASK_W-1:0] lat_wmask;
    logic              accept;
    logic              commit;
    logic [XLEN-1:0]   off;
    logic [XLEN-1:0]   word_off;
    logic              in_range;
    logic [XLEN-1:0]   arr_rdata;

    // Below-BASE addresses wrap to huge offsets, so both bounds are checked.
    assign off      = lat_addr - BASE;
    assign word_off = off >> 3;
    assign in_range = (lat_addr >= BASE) && (word_off < XLEN'(DEPTH));

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    commit     = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            lat_wen    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wmask  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                cnt       <= CNT_INIT;
                lat_wen   <= req_wen;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_wmask <= req_wmask;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (commit) begin
                resp_rdata <= (in_range && !lat_wen) ? arr_rdata : '0;
                resp_err   <= !in_range;
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .wen   (commit && in_range && lat_wen),
        .idx   (word_off[IDX_W-1:0]),
        .wmask (lat_wmask),
        .wdata (lat_wdata),
        .rdata (arr_rdata)
    );

endmodule
